spi_target_regs: RTL
====================

Name: spi_target_regs

Overview:
- SPI mode-0 target (responder) block. It is the far end of the SoC's spi0 master port (SCLK/MOSI/SS_n out, MISO in).
- Exposes a small byte-wide register file to the host over SPI, and mirrors the live text-controller keycode into register 0.
- Used for board-to-board links and for self-test loopback of the spi0 master.
- All SPI inputs are oversampled by the system clock; no logic is clocked by SCLK.

Parameters:
- ADDR_W, 3: register address width; the file holds 2^ADDR_W bytes.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers on SCLK, MOSI and SS_n; minimum 2.

Ports:
- Clk  in  1  system clock; must be at least 8x the SCLK frequency.
- Reset  in  1  synchronous, active-high reset.
- SPI_SCLK  in  1  SPI clock from the host; idles low (mode 0).
- SPI_MOSI  in  1  host-to-target data, MSB first.
- SPI_SS_n  in  1  active-low select.
- SPI_MISO  out  1  target-to-host data.
- SPI_MISO_oe  out  1  MISO output enable; high only while selected.
- keycode  in  8  live keycode; read-only image of register 0.
- regs_flat  out  8*2^ADDR_W  all register contents; byte i is at [8i+7:8i]; byte 0 equals keycode.
- wr_strobe  out  1  one-cycle pulse per committed write.
- wr_addr  out  ADDR_W  address of the committed write.
- wr_data  out  8  data of the committed write.
- busy  out  1  high while a transaction is active.
- irq  out  1  keycode-change interrupt (see Optional Feature).

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - registers 1..N-1 = 0x00, state=IDLE, SPI_MISO=0, SPI_MISO_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, irq=0.
  - If SS_n is low when Reset is released, the block stays in IDLE until a synchronized SS_n high is seen, then re-arms.
- Edge detection:
  - SCLK, MOSI and SS_n each pass through SYNC_STAGES flops.
  - Rise/fall are detected by comparing the last synchronized stage with one more registered copy.
  - Response latency is SYNC_STAGES+1 Clk cycles from the pin.
- States: IDLE, CMD, DATA.
- IDLE:
  - SS_n fall -> enter CMD, bit_cnt=0.
  - tx shift register loaded with the status byte (the keycode value at that Clk edge).
  - SPI_MISO_oe=1, busy=1.
- SPI_MISO always equals tx[7] while selected, and 0 otherwise.
- SCLK rise:
  - rx = {rx[6:0], MOSI}; bit_cnt increments and wraps modulo 8.
  - On the 8th rise, the assembled byte B is handled by state:
- CMD, on byte B:
  - addr = B[ADDR_W+2:3], so command address bits above ADDR_W alias.
  - wr = B[1]; bits 2 and 0 are ignored.
  - next_byte = reg[addr]; go to DATA.
- DATA, on byte B:
  - If wr=1 and addr!=0: reg[addr]=B, and wr_strobe pulses for exactly 1 Clk with wr_addr=addr and wr_data=B.
  - If addr==0, writes are silently dropped with no strobe.
  - addr then increments, wrapping from 2^ADDR_W-1 to 0.
  - next_byte = reg[new addr], taking the value after the write just committed.
- SCLK fall:
  - If bit_cnt==0, tx=next_byte; otherwise tx=tx<<1.
  - The MSB of each new byte is therefore on MISO before the first rise of that byte.
- SS_n rise, in any state:
  - Return to IDLE the next Clk; SPI_MISO_oe=0, busy=0.
  - A partial byte is discarded and no write occurs.
- Simultaneous events:
  - An SCLK edge detected in the same Clk as SS_n rise is ignored.
  - SCLK edges while in IDLE are ignored.
  - A CMD-only transaction (8 bits, then deselect) performs no register access.
- Reset mid-transaction: the transaction is aborted and no write is committed; the re-arm rule above applies.

Optional Feature:
- Macro: SPI_TARGET_IRQ_EN.
- Defined:
  - irq is set on the Clk after keycode differs from its registered previous value.
  - irq is cleared when a CMD byte completes with addr==0 and wr==0.
  - If a keycode change and that clear occur in the same cycle, set wins.
- Undefined: the irq port still exists and is tied to 0; no change-detect flops are built.

Test Plan:
- Write: Reset, keycode=0x1A; host sends cmd 0x0A (addr1, write), data 0x5C, deselect. Required: regs_flat[15:8]=0x5C; one wr_strobe with wr_addr=1, wr_data=0x5C; MISO bytes seen by host are 0x1A, 0x00.
- Burst write with wrap: cmd 0x3A (addr7, write), data 0x11, 0x22. Required: reg7=0x11; the write to addr 0 is dropped with no strobe; exactly 1 strobe total.
- Burst read: regs 2/3 preloaded with 0xA5/0x3C; cmd 0x10 (addr2, read) plus two dummy bytes. Required: MISO returns 0x1A (status), 0xA5, 0x3C; no wr_strobe.
- Abort: cmd 0x0A then 5 data bits, then SS_n high. Required: reg1 unchanged, no strobe, busy=0 and MISO_oe=0 within SYNC_STAGES+2 cycles.
- Reset mid-transaction: Reset pulsed while SS_n is low mid-data; remaining SCLKs clocked. Required: no writes and MISO=0. After SS_n high->low, a normal transaction succeeds.
- IRQ (macro defined): keycode changes 0x00->0x04. Required: irq=1 after one Clk. Cmd 0x00 then deselect -> irq=0. With macro undefined, irq stays 0 throughout.

Source files
------------

// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target exposing a 2^ADDR_W byte register file.
// Every SPI pin is oversampled by Clk; no logic is clocked by SCLK.
// Register 0 is a read-only image of keycode; writes to it are dropped.
// Optional macro SPI_TARGET_IRQ_EN builds the keycode-change interrupt;
// without it irq is tied low and no change-detect flops exist.
module spi_target_regs #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       SPI_SCLK,
    input  logic                       SPI_MOSI,
    input  logic                       SPI_SS_n,
    output logic                       SPI_MISO,
    output logic                       SPI_MISO_oe,
    input  logic [7:0]                 keycode,
    output logic [8*(2**ADDR_W)-1:0]   regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       busy,
    output logic                       irq
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCmd  = 2'd1;
    localparam logic [1:0] StData = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_last, mosi_last, ss_last;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [1:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        next_q, next_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] cmd_addr, addr_inc;
    logic              cmd_wr, active, byte_done, wr_en;

    logic [7:0]        regs_q [1:NREG-1];
    logic [7:0]        rd_view [NREG];

    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    // Input synchronizers plus one extra registered copy for edge detection.
    // Reset clears them to 0 so an SS_n already low at release reads as no
    // edge: the block only re-arms after it has seen SS_n high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS_n};
            sclk_prev_q <= sclk_last;
            ss_prev_q   <= ss_last;
        end
    end

    assign sclk_last = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_last = mosi_sync_q[SYNC_STAGES-1];
    assign ss_last   = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_last & ~sclk_prev_q;
    assign sclk_fall = ~sclk_last & sclk_prev_q;
    assign ss_rise   = ss_last & ~ss_prev_q;
    assign ss_fall   = ~ss_last & ss_prev_q;

    assign active    = (state_q != StIdle);
    assign rx_byte   = {rx_q, mosi_last};
    assign cmd_addr  = rx_byte[ADDR_W+2:3];
    assign cmd_wr    = rx_byte[1];
    assign addr_inc  = addr_q + ADDR_W'(1);
    // A deselect in the same cycle swallows any SCLK edge.
    assign byte_done = active & ~ss_rise & sclk_rise & (bit_cnt_q == 3'd7);
    assign wr_en     = byte_done & (state_q == StData) & wr_q & (addr_q != '0);

    // Read view of the register file with keycode as byte 0, and its flat image.
    always_comb begin
        rd_view[0]       = keycode;
        regs_flat[7:0]   = keycode;
        for (int i = 1; i < NREG; i++) begin
            rd_view[i]          = regs_q[i];
            regs_flat[8*i +: 8] = regs_q[i];
        end
    end

    // Transaction next-state: select, bit shifting and per-byte command/data handling.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        next_d    = next_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        if (!active) begin
            if (ss_fall) begin
                state_d   = StCmd;
                bit_cnt_d = 3'd0;
                rx_d      = '0;
                tx_d      = keycode;
            end
        end else if (ss_rise) begin
            state_d = StIdle;
        end else if (sclk_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (state_q == StCmd) begin
                    addr_d  = cmd_addr;
                    wr_d    = cmd_wr;
                    next_d  = rd_view[cmd_addr];
                    state_d = StData;
                end else begin
                    addr_d = addr_inc;
                    // Forward the byte being committed if the read hits it.
                    next_d = (wr_en && addr_inc == addr_q) ? rx_byte : rd_view[addr_inc];
                end
            end
        end else if (sclk_fall) begin
            tx_d = (bit_cnt_q == 3'd0) ? next_q : {tx_q[6:0], 1'b0};
        end
    end

    // Transaction state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            next_q    <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            next_q    <= next_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
        end
    end

    // Register file writes and the committed-write report.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= wr_en;
            if (wr_en) begin
                regs_q[addr_q] <= rx_byte;
                wr_addr_q      <= addr_q;
                wr_data_q      <= rx_byte;
            end
        end
    end

    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = active;
    assign SPI_MISO_oe = active;
    assign SPI_MISO    = active & tx_q[7];

`ifdef SPI_TARGET_IRQ_EN
    logic [7:0] key_prev_q;
    logic       irq_q;
    logic       irq_clr;

    assign irq_clr = byte_done & (state_q == StCmd) & (cmd_addr == '0) & ~cmd_wr;

    // Keycode change detect; a change in the same cycle as a clear wins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_prev_q <= keycode;
            irq_q      <= 1'b0;
        end else begin
            key_prev_q <= keycode;
            if (keycode != key_prev_q) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
